tern_matvec_scheduler: RTL
==========================

TERN_MATVEC_SCHEDULER -- requirements
Module: tern_matvec_scheduler

Interface
REQ-001 SHALL have parameter VEC_LEN, 4096, activation vector length and weight row length.
REQ-002 SHALL have parameter CHUNK, 256, activations summed per datapath pass; NCHUNK = VEC_LEN/CHUNK = 16.
REQ-003 SHALL have parameter ACC_W, 20, signed result width.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  in  1  begin a matrix-vector job.
REQ-007 SHALL have port n_rows  in  13  rows in the job, 0..4096.
REQ-008 SHALL have port busy  out  1  job in progress.
REQ-009 SHALL have port done  out  1  one-cycle end-of-job pulse.
REQ-010 SHALL have port w_req_valid  out  1  chunk request to the ternary datapath.
REQ-011 SHALL have port w_req_ready  in  1  datapath accepts the request.
REQ-012 SHALL have port w_req_row  out  12  weight row index.
REQ-013 SHALL have port w_req_chunk  out  4  chunk index within the row.
REQ-014 SHALL have port chunk_sum_valid  in  1  datapath partial sum available.
REQ-015 SHALL have port chunk_sum  in  17  signed sum of one chunk of ternary products.
REQ-016 SHALL have port res_valid  out  1  row result valid.
REQ-017 SHALL have port res_ready  in  1  consumer accepts result.
REQ-018 SHALL have port res_row  out  12  row index of result.
REQ-019 SHALL have port res_data  out  ACC_W  signed saturated row dot product.

Function
REQ-020 SHALL use FSM states IDLE, REQ, WAIT, OUT.
REQ-021 SHALL, in IDLE with start=1 and n_rows>0, clear row/chunk counters and accumulator and enter REQ next cycle; busy=1 from that cycle.
REQ-022 SHALL, on start with n_rows=0, pulse done the next cycle, stay IDLE, issue no request.
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL in REQ hold w_req_valid=1 with stable row/chunk until w_req_valid&w_req_ready, then enter WAIT.
REQ-025 SHALL keep at most one request outstanding; chunk_sum_valid outside WAIT is ignored.
REQ-026 SHALL in WAIT, on chunk_sum_valid, add sign-extended chunk_sum into a 21-bit accumulator; if chunk<NCHUNK-1 increment chunk and return to REQ, else enter OUT.
REQ-027 SHALL tolerate any datapath latency, including chunk_sum_valid in the cycle after acceptance.
REQ-028 SHALL in OUT drive res_valid=1, res_row=current row, res_data=accumulator saturated to [-524288, 524287]; hold stable until res_ready.
REQ-029 SHALL on res_valid&res_ready: if row<n_rows-1 increment row, zero chunk and accumulator, enter REQ; else pulse done, drop busy, enter IDLE the same edge.
REQ-030 SHALL latch n_rows at start; later n_rows changes do not affect the job.
REQ-031 SHALL sustain one chunk per two cycles with zero-latency datapath and res_ready=1.

Reset
REQ-032 SHALL on rst force IDLE and busy, done, w_req_valid, res_valid, w_req_row, w_req_chunk, res_row, res_data, counters and accumulator to 0 immediately, including mid-job; no result emitted for an aborted row.

Structure
REQ-033 SHALL place VEC_LEN, CHUNK, NCHUNK, ACC_W, chunk-sum width and the state enum in package tern_pkg.
REQ-034 SHALL implement accumulate/clear/saturate in sub-module tern_row_accumulator.

Verification
REQ-035 SHALL test n_rows=1, every chunk_sum=+10 -> one result row 0, data 160, done one cycle after res handshake.
REQ-036 SHALL test n_rows=3, chunk_sum=+32767 x16 per row -> each res_data=524272 (no saturation); rows 0,1,2 in order.
REQ-037 SHALL test chunk_sum=-32768 x16 -> res_data=-524288; +32768-equivalent overflow via 16x(+32767)+extra pass forced -> saturation at 524287.
REQ-038 SHALL test w_req_ready low 5 cycles and res_ready low 3 cycles -> request and result held stable, no lost or duplicate chunk.
REQ-039 SHALL test rst asserted in WAIT of row 2 -> all outputs 0 immediately, later start runs a fresh job from row 0.
REQ-040 SHALL test start with n_rows=0 and start while busy -> done pulse only, no requests; second start ignored.

Source files
------------

// File: rtl/tern_pkg.sv
// Shared constants, FSM state type and saturation helper for the ternary mat-vec scheduler.
package tern_pkg;

   localparam int unsigned VEC_LEN   = 4096;
   localparam int unsigned CHUNK     = 256;
   localparam int unsigned NCHUNK    = VEC_LEN / CHUNK;
   localparam int unsigned ACC_W     = 20;
   localparam int unsigned CSUM_W    = 17;
   localparam int unsigned CHUNK_W   = $clog2(NCHUNK);
   // Wide enough that NCHUNK full-scale chunk sums can never wrap before saturation.
   localparam int unsigned ACC_INT_W = CSUM_W + CHUNK_W;
   localparam int unsigned ROW_W     = 12;
   localparam int unsigned NROWS_W   = 13;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StOut
   } state_e;

   function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_INT_W-1:0] v);
      logic [ACC_W-1:0] r;
      if (!v[ACC_INT_W-1] && |v[ACC_INT_W-2:ACC_W-1]) begin
         r = {1'b0, {(ACC_W-1){1'b1}}};
      end else if (v[ACC_INT_W-1] && !(&v[ACC_INT_W-2:ACC_W-1])) begin
         r = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
         r = v[ACC_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/tern_row_accumulator.sv
// Row accumulator: clears, adds sign-extended chunk sums, and exposes the saturated next value.
module tern_row_accumulator
   import tern_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              add,
   input  logic [CSUM_W-1:0] chunk_sum,
   output logic [ACC_W-1:0]  sat_next
);

   logic [ACC_INT_W-1:0] acc_q;
   logic [ACC_INT_W-1:0] acc_d;

   always_comb begin
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (add) begin
         acc_d = acc_q + {{(ACC_INT_W-CSUM_W){chunk_sum[CSUM_W-1]}}, chunk_sum};
      end
   end

   // Saturated view of the value being written this cycle, so the result register
   // can capture the final chunk's contribution on the same edge.
   assign sat_next = sat_acc(acc_d);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/tern_matvec_scheduler.sv
// Walks rows and chunks of a ternary matrix-vector job, one outstanding datapath request at a time.
module tern_matvec_scheduler #(
   parameter int unsigned VEC_LEN = tern_pkg::VEC_LEN,
   parameter int unsigned CHUNK   = tern_pkg::CHUNK,
   parameter int unsigned ACC_W   = tern_pkg::ACC_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [12:0]                n_rows,
   output logic                       busy,
   output logic                       done,
   output logic                       w_req_valid,
   input  logic                       w_req_ready,
   output logic [11:0]                w_req_row,
   output logic [3:0]                 w_req_chunk,
   input  logic                       chunk_sum_valid,
   input  logic [16:0]                chunk_sum,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [11:0]                res_row,
   output logic [ACC_W-1:0]           res_data
);

   import tern_pkg::*;

   localparam int unsigned LastChunk = VEC_LEN / CHUNK - 1;

   state_e             state;
   logic [NROWS_W-1:0] n_rows_q;
   logic               last_row;
   logic               acc_clr;
   logic               acc_add;
   logic [ACC_W-1:0]   sat_next;

   assign last_row = ({1'b0, w_req_row} == n_rows_q - NROWS_W'(1));

   always_comb begin
      acc_clr = 1'b0;
      acc_add = 1'b0;
      case (state)
         StIdle:  acc_clr = start && (n_rows != '0);
         StWait:  acc_add = chunk_sum_valid;
         StOut:   acc_clr = res_ready;
         default: acc_clr = 1'b0;
      endcase
   end

   tern_row_accumulator u_acc (
      .clk       (clk),
      .rst       (rst),
      .clr       (acc_clr),
      .add       (acc_add),
      .chunk_sum (chunk_sum),
      .sat_next  (sat_next)
   );

   // w_req_row / w_req_chunk double as the row and chunk counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= StIdle;
         busy        <= 1'b0;
         done        <= 1'b0;
         w_req_valid <= 1'b0;
         w_req_row   <= '0;
         w_req_chunk <= '0;
         res_valid   <= 1'b0;
         res_row     <= '0;
         res_data    <= '0;
         n_rows_q    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            StIdle: begin
               if (start) begin
                  if (n_rows != '0) begin
                     n_rows_q    <= n_rows;
                     w_req_row   <= '0;
                     w_req_chunk <= '0;
                     busy        <= 1'b1;
                     w_req_valid <= 1'b1;
                     state       <= StReq;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            StReq: begin
               if (w_req_ready) begin
                  w_req_valid <= 1'b0;
                  state       <= StWait;
               end
            end
            StWait: begin
               if (chunk_sum_valid) begin
                  if (w_req_chunk != CHUNK_W'(LastChunk)) begin
                     w_req_chunk <= w_req_chunk + 4'd1;
                     w_req_valid <= 1'b1;
                     state       <= StReq;
                  end else begin
                     res_valid <= 1'b1;
                     res_row   <= w_req_row;
                     res_data  <= sat_next;
                     state     <= StOut;
                  end
               end
            end
            StOut: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (!last_row) begin
                     w_req_row   <= w_req_row + 12'd1;
                     w_req_chunk <= '0;
                     w_req_valid <= 1'b1;
                     state       <= StReq;
                  end else begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= StIdle;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
